// File: rtl/xrv_pkg.sv
// Shared definitions for the xrv multi-cycle core: fetch FSM states and fetch constants.
package xrv_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } fetch_state_e;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          INST_BYTES = 4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, single-outstanding imem requests, one-entry
// instruction buffer, branch redirect with stale-response kill and misalign halt.
module fetch_unit
  import xrv_pkg::*;
#(
  parameter int            AW       = 32,
  parameter int            DW       = 32,
  parameter logic [AW-1:0] RESET_PC = AW'(xrv_pkg::RESET_PC)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          redirect_i,
  input  logic [AW-1:0] redirect_pc_i,
  output logic          imem_req_valid_o,
  input  logic          imem_req_ready_i,
  output logic [AW-1:0] imem_req_addr_o,
  input  logic          imem_rsp_valid_i,
  input  logic [DW-1:0] imem_rsp_data_i,
  input  logic          imem_rsp_err_i,
  output logic          inst_valid_o,
  input  logic          inst_ready_i,
  output logic [DW-1:0] inst_data_o,
  output logic [AW-1:0] inst_pc_o,
  output logic          inst_err_o,
  output logic          misalign_o,
  output logic [AW-1:0] misalign_pc_o
);

  fetch_state_e  state;
  logic [AW-1:0] pc;
  logic          kill;

  logic req_fire;
  logic rsp_pending;
  logic outstanding_next;

  assign imem_req_valid_o = (state == S_REQ);
  assign imem_req_addr_o  = pc;
  assign inst_valid_o     = (state == S_HOLD);

  // A halted fetch may still owe us a response if it was redirected mid-request.
  assign req_fire         = (state == S_REQ) && imem_req_ready_i;
  assign rsp_pending      = (state == S_WAIT) || ((state == S_HALT) && kill);
  assign outstanding_next = req_fire || (rsp_pending && !imem_rsp_valid_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= S_REQ;
      pc            <= RESET_PC;
      kill          <= 1'b0;
      inst_data_o   <= '0;
      inst_pc_o     <= '0;
      inst_err_o    <= 1'b0;
      misalign_o    <= 1'b0;
      misalign_pc_o <= '0;
    end else begin
      misalign_o <= 1'b0;
      if (redirect_i) begin
        kill <= outstanding_next;
        if (redirect_pc_i[1:0] == 2'b00) begin
          pc    <= redirect_pc_i;
          state <= outstanding_next ? S_WAIT : S_REQ;
        end else begin
          misalign_o    <= 1'b1;
          misalign_pc_o <= redirect_pc_i;
          state         <= S_HALT;
        end
      end else begin
        case (state)
          S_REQ: begin
            if (imem_req_ready_i) state <= S_WAIT;
          end
          S_WAIT: begin
            if (imem_rsp_valid_i) begin
              if (kill) begin
                kill  <= 1'b0;
                state <= S_REQ;
              end else begin
                inst_data_o <= imem_rsp_data_i;
                inst_pc_o   <= pc;
                inst_err_o  <= imem_rsp_err_i;
                pc          <= pc + AW'(INST_BYTES);
                state       <= S_HOLD;
              end
            end
          end
          S_HOLD: begin
            if (inst_ready_i) state <= S_REQ;
          end
          S_HALT: begin
            if (imem_rsp_valid_i) kill <= 1'b0;
          end
          default: state <= S_REQ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, redirects, misalign halt, wrap, async reset.
module tb_fetch_unit;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          redirect_i;
  logic [AW-1:0] redirect_pc_i;
  logic          imem_req_valid_o;
  logic          imem_req_ready_i;
  logic [AW-1:0] imem_req_addr_o;
  logic          imem_rsp_valid_i;
  logic [DW-1:0] imem_rsp_data_i;
  logic          imem_rsp_err_i;
  logic          inst_valid_o;
  logic          inst_ready_i;
  logic [DW-1:0] inst_data_o;
  logic [AW-1:0] inst_pc_o;
  logic          inst_err_o;
  logic          misalign_o;
  logic [AW-1:0] misalign_pc_o;

  int checks = 0;
  int errors = 0;

  fetch_unit #(.AW(AW), .DW(DW), .RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .imem_rsp_err_i   (imem_rsp_err_i),
    .inst_valid_o     (inst_valid_o),
    .inst_ready_i     (inst_ready_i),
    .inst_data_o      (inst_data_o),
    .inst_pc_o        (inst_pc_o),
    .inst_err_o       (inst_err_o),
    .misalign_o       (misalign_o),
    .misalign_pc_o    (misalign_pc_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full fetch from S_REQ: accept, 1-cycle response, decode accepts.
  task automatic do_fetch(input logic [AW-1:0] addr, input logic [DW-1:0] data, input logic err);
    chk("req_valid", 64'(imem_req_valid_o), 64'd1);
    chk("req_addr", 64'(imem_req_addr_o), 64'(addr));
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i = 1'b0;
    chk("wait_no_req", 64'(imem_req_valid_o), 64'd0);
    chk("wait_no_inst", 64'(inst_valid_o), 64'd0);
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = data;
    imem_rsp_err_i   = err;
    step();
    imem_rsp_valid_i = 1'b0;
    imem_rsp_err_i   = 1'b0;
    chk("inst_valid", 64'(inst_valid_o), 64'd1);
    chk("inst_data", 64'(inst_data_o), 64'(data));
    chk("inst_pc", 64'(inst_pc_o), 64'(addr));
    chk("inst_err", 64'(inst_err_o), 64'(err));
    chk("hold_no_req", 64'(imem_req_valid_o), 64'd0);
    inst_ready_i = 1'b1;
    step();
    inst_ready_i = 1'b0;
    chk("inst_consumed", 64'(inst_valid_o), 64'd0);
  endtask

  initial begin
    rst              = 1'b1;
    redirect_i       = 1'b0;
    redirect_pc_i    = '0;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    imem_rsp_err_i   = 1'b0;
    inst_ready_i     = 1'b0;
    step();
    step();
    chk("rst_inst_valid", 64'(inst_valid_o), 64'd0);
    chk("rst_inst_data", 64'(inst_data_o), 64'd0);
    chk("rst_inst_pc", 64'(inst_pc_o), 64'd0);
    chk("rst_inst_err", 64'(inst_err_o), 64'd0);
    chk("rst_misalign", 64'(misalign_o), 64'd0);
    chk("rst_misalign_pc", 64'(misalign_pc_o), 64'd0);
    rst = 1'b0;
    step();

    // sequential fetch, error flag on 0x8 does not stop fetch
    do_fetch(32'h0, 32'h1111_0001, 1'b0);
    do_fetch(32'h4, 32'h2222_0002, 1'b0);
    do_fetch(32'h8, 32'h3333_0003, 1'b1);
    do_fetch(32'hC, 32'h4444_0004, 1'b0);

    // redirect while waiting: stale response dropped
    chk("pre_wait_addr", 64'(imem_req_addr_o), 64'h10);
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h100;
    step();
    redirect_i = 1'b0;
    chk("kill_no_req", 64'(imem_req_valid_o), 64'd0);
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid_i = 1'b0;
    chk("stale_no_inst", 64'(inst_valid_o), 64'd0);
    do_fetch(32'h100, 32'h5555_0005, 1'b0);

    // redirect while holding with decode stalled
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'h6666_0006;
    step();
    imem_rsp_valid_i = 1'b0;
    chk("hold_valid", 64'(inst_valid_o), 64'd1);
    chk("hold_pc", 64'(inst_pc_o), 64'h104);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h200;
    step();
    redirect_i = 1'b0;
    chk("hold_redir_flush", 64'(inst_valid_o), 64'd0);
    do_fetch(32'h200, 32'h7777_0007, 1'b0);

    // misaligned redirect halts fetch
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h102;
    step();
    redirect_i       = 1'b0;
    imem_req_ready_i = 1'b1;
    chk("misalign_pulse", 64'(misalign_o), 64'd1);
    chk("misalign_pc", 64'(misalign_pc_o), 64'h102);
    chk("halt_no_req", 64'(imem_req_valid_o), 64'd0);
    step();
    chk("misalign_one_cycle", 64'(misalign_o), 64'd0);
    chk("misalign_pc_held", 64'(misalign_pc_o), 64'h102);
    step();
    chk("halt_still_no_req", 64'(imem_req_valid_o), 64'd0);
    imem_req_ready_i = 1'b0;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h300;
    step();
    redirect_i = 1'b0;
    do_fetch(32'h300, 32'h8888_0008, 1'b0);

    // redirect coinciding with the response
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b1;
    imem_rsp_data_i  = 32'hBAD0_BAD0;
    redirect_i       = 1'b1;
    redirect_pc_i    = 32'h400;
    step();
    imem_rsp_valid_i = 1'b0;
    redirect_i       = 1'b0;
    chk("coincide_no_inst", 64'(inst_valid_o), 64'd0);
    do_fetch(32'h400, 32'h9999_0009, 1'b0);

    // pc increment wraps
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    step();
    redirect_i = 1'b0;
    do_fetch(32'hFFFF_FFFC, 32'hAAAA_000A, 1'b0);
    chk("wrap_addr", 64'(imem_req_addr_o), 64'h0);

    // async reset while waiting
    imem_req_ready_i = 1'b1;
    step();
    imem_req_ready_i = 1'b0;
    chk("pre_rst_wait", 64'(imem_req_valid_o), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_req_valid", 64'(imem_req_valid_o), 64'd1);
    chk("arst_req_addr", 64'(imem_req_addr_o), 64'h0);
    chk("arst_inst_data", 64'(inst_data_o), 64'd0);
    chk("arst_inst_pc", 64'(inst_pc_o), 64'd0);
    chk("arst_misalign_pc", 64'(misalign_pc_o), 64'd0);
    step();
    rst = 1'b0;
    step();
    do_fetch(32'h0, 32'hBBBB_000B, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
